// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  // Controller states. The encoding 2'd3 is never entered; if it appears,
  // the next-state logic sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder built from two half adders.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic h1_s;

  // The first half adder combines a and b. The second half adder folds in the carry.
  always_comb begin
    h1_s = a ^ b;
    s    = h1_s ^ c;
    co   = (a & b) | (c & h1_s);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. One full-adder cell is stepped over WIDTH-bit
// operands, LSB first, one bit per clock, behind a start/done handshake.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             load;
  logic             last;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // start is honoured only in IDLE or DONE. When start arrives in DONE, a new
  // operation begins back-to-back.
  always_comb begin
    load = start && ((state == IDLE) || (state == DONE));
    last = (state == SHIFT) && (cnt == LAST_BIT);
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Next-state logic.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? SHIFT : IDLE;
      SHIFT:   state_next = last ? DONE : SHIFT;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture and the serial datapath. sum and cout change only on the
  // final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      res_sr <= {fa_s, res_sr[WIDTH-1:1]};
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_s, res_sr[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl. It uses one WIDTH=8 instance and
// one WIDTH=2 instance, and compares them against plain integer addition.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int total = 0;
  int bad = 0;
  logic [8:0] prev8 = '0;
  logic [2:0] prev2 = '0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=8 addition, starting from IDLE just after an edge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    logic [8:0] exp;
    exp = 9'(ta) + 9'(tb) + 9'(tc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    // Scramble the inputs. The captured operands must be the only ones used.
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("busy_shift", busy, 1'b1);
      check("done_shift", done, 1'b0);
      check("hold_shift", {cout, sum}, prev8);
      step();
    end
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("result8", {cout, sum}, exp);
    $display("add8 a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h (exp %03h)", ta, tb, tc, cout, sum, exp);
    step();
    check("done_once", done, 1'b0);
    check("hold_idle", {cout, sum}, exp);
    prev8 = exp;
  endtask

  // Runs one WIDTH=2 addition on the second instance.
  task automatic run2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
    logic [2:0] exp;
    exp = 3'(ta) + 3'(tb) + 3'(tc);
    a2 = ta; b2 = tb; cin2 = tc; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("busy2_shift", busy2, 1'b1);
      check("hold2_shift", {cout2, sum2}, prev2);
      step();
    end
    check("done2_pulse", done2, 1'b1);
    check("result2", {cout2, sum2}, exp);
    $display("add2 a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d (exp %0d)", ta, tb, tc, cout2, sum2, exp);
    step();
    check("done2_once", done2, 1'b0);
    prev2 = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int first_done;
    int second_done;

    // Reset state.
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", {cout, sum}, 9'h000);
    check("rst_out2", {cout2, sum2}, 3'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // Directed vectors.
    run8(8'h00, 8'h00, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1);
    run8(8'h3C, 8'h0F, 1'b0);

    // A start during SHIFT is ignored.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 3);
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF;
      end
      step();
      if (done) begin
        ndone++;
        check("mid_start_result", {cout, sum}, 9'h046);
      end
    end
    start = 1'b0;
    check("mid_start_ndone", ndone, 1);
    $display("mid-shift start: done pulses=%0d sum=%02h cout=%0d", ndone, sum, cout);
    prev8 = 9'h046;

    // Start held high produces back-to-back operations.
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    step();
    ndone = 0; first_done = -1; second_done = -1;
    for (int c = 1; c < 20; c++) begin
      step();
      check("held_busy", busy, !done);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c; else second_done = c;
        check("held_result", {cout, sum}, 9'h100);
      end
    end
    start = 1'b0;
    check("held_ndone", ndone, 2);
    check("held_first", first_done, 8);
    check("held_spacing", second_done - first_done, 9);
    $display("held start: done at +%0d and +%0d", first_done, second_done);
    repeat (10) step();
    prev8 = 9'h100;

    // Asynchronous reset in the middle of SHIFT.
    run8(8'h10, 8'h20, 1'b0);
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #3 rst = 1'b1;
    #1;
    check("arst_out", {cout, sum}, 9'h000);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    $display("async reset mid-shift: busy=%0d done=%0d sum=%02h cout=%0d", busy, done, sum, cout);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      step();
    end
    check("arst_no_done", ndone, 0);
    prev8 = '0;
    prev2 = '0;
    run8(8'h77, 8'h11, 1'b0);

    // Exhaustive WIDTH=2.
    for (int i = 0; i < 32; i++) begin
      run2(2'(i >> 3), 2'(i >> 1), 1'(i));
    end

    // Random WIDTH=8.
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
